mem_access_initiator: RTL and testbench
=======================================

// Module: mem_access_initiator
// PURPOSE
//  Initiator end of the MOV/MOC memory handshake. Accepts one load/store request per transaction from the
//  control unit, drives MOV/RW/address/data/OP into the byte-addressed RAM, waits for MOC, sign/zero-extends
//  load data and returns a one-cycle response. Checks alignment and range, and enforces a MOC timeout.
// PARAMETERS
//  MEM_BYTES      512  addressable bytes; any access touching byte >= MEM_BYTES faults
//  TIMEOUT_CYC    16   cycles in WAIT without MOC before a timeout fault (range 2..255)
// PORTS
//  Clk           in   1   clock, all state on posedge
//  Clr           in   1   reset, asynchronous, active-high
//  req_valid     in   1   request present; sampled only while req_ready=1
//  req_ready     out  1   1 in IDLE only
//  req_op        in   6   LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified
//  rsp_valid     out  1   one-cycle pulse: transaction finished
//  rsp_rdata     out  32  extended load data (0 for stores and faults); held until the next rsp_valid
//  rsp_fault     out  1   with rsp_valid: transaction aborted
//  rsp_code      out  2   00 ok, 01 misaligned, 10 out of range, 11 timeout; held with rsp_rdata
//  MOV           out  1   memory operation valid
//  RW            out  1   1 read, 0 write; idles at 1
//  MemAddr       out  32  address to RAM
//  MemDataIn     out  32  write data to RAM
//  MemOP         out  6   OP to RAM (RAM-native codes only)
//  MemDataOut    in   32  read data from RAM (big-endian, right-justified, zero-filled)
//  MOC           in   1   memory operation complete
// BEHAVIOUR
//  Reset: state IDLE; MOV=0, RW=1, MemAddr/MemDataIn/rsp_rdata=0, MemOP=6'b100011, rsp_valid/rsp_fault=0,
//   rsp_code=00, timeout counter=0. Clr mid-transaction drops MOV in the same cycle (async). No response.
//  FSM IDLE -> CHECK -> SETUP -> WAIT -> DONE -> IDLE. A fault goes from CHECK or WAIT to DONE.
//  IDLE: on req_valid, register op/addr/wdata and go to CHECK. Illegal op: treated as LW (no fault).
//  CHECK: size 1/2/4 B. Misaligned (halfword addr[0]!=0, word addr[1:0]!=0) -> code 01.
//   Else addr+size > MEM_BYTES (33-bit compare, no wrap) -> code 10. Misaligned wins if both apply.
//   No fault: go to SETUP.
//  SETUP: MOV=1; RW=1 for loads, 0 for stores. MemOP: LBU->100000, LHU->100001, others pass through.
//   MemDataIn=wdata. Address, data, RW and OP stay stable until MOV falls. MOC is ignored in SETUP
//   because it can be stale high from the previous access.
//  WAIT: MOV held at 1; counter increments each cycle. On MOC=1, capture MemDataOut and go to DONE.
//   If counter reaches TIMEOUT_CYC-1 without MOC, code 11 and go to DONE.
//   MOC and timeout in the same cycle: MOC wins.
//  DONE: MOV=0, RW=1; rsp_valid=1 for exactly one cycle; counter cleared.
//   LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
//  Load-to-response latency without wait states: 4 cycles from the req_valid sample edge to rsp_valid.
//   Each extra MOC wait cycle adds 1. Faulted requests never assert MOV.
//  req_valid while busy is ignored; the requester must hold it until req_ready.
// STRUCTURE
//  Shared package (mem_pkg.vh): opcode localparams, size encoding, fault codes, FSM state encoding.
//  One natural sub-module: load_extender (op, raw[31:0] -> ext[31:0]), purely combinational.
//  The FSM, counter and address checker stay in this module.
// TESTING (bench pairs this block with a behavioural RAM whose MOC delay is programmable)
//  SW 0x0000_0010 data 0xDEAD_BEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, code 00; 4 cycles at 0 wait.
//  SB 0x20 data 0x0000_0080; then LB 0x20 -> 0xFFFF_FF80; then LBU 0x20 -> 0x0000_0080, MemOP=100000.
//  LH 0x31 -> rsp_fault=1, code 01, MOV never high; LW 0x1FE -> code 01 (misaligned wins over range).
//  LW 0x1FC -> ok; LW 0x200 -> code 10; SH 0x1FF -> code 01; LB 0xFFFF_FFFF -> code 10 (no wrap).
//  RAM with MOC held low, TIMEOUT_CYC=16 -> rsp code 11 after 16 WAIT cycles, MOV falls in DONE.
//   MOC delay set to TIMEOUT_CYC-1 -> code 00.
//  Clr pulsed during WAIT -> MOV low immediately, no rsp_valid, req_ready=1 after release;
//   a following LW completes normally.

Source files
------------

// File: rtl/mem_access_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_initiator_pkg
//   Shared definitions for the MOV/MOC memory initiator: opcode values, access
//   size encoding, response codes, FSM state encoding and small decode helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package mem_access_initiator_pkg;

   // Opcodes as issued by the control unit
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   // Access size
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // Response codes
   localparam logic [1:0] CODE_OK       = 2'b00;
   localparam logic [1:0] CODE_MISALIGN = 2'b01;
   localparam logic [1:0] CODE_RANGE    = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

   // FSM state encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_SETUP = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic op_legal(input logic [5:0] op);
      logic ok;
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Unknown opcodes are quietly executed as a word load.
   function automatic logic [5:0] op_normalize(input logic [5:0] op);
      return op_legal(op) ? op : OP_LW;
   endfunction

   function automatic size_e op_size(input logic [5:0] op);
      size_e sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
         default:              sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic [2:0] size_bytes(input size_e sz);
      logic [2:0] n;
      case (sz)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   function automatic logic op_is_store(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // The RAM only knows signed-style load codes; unsigned loads map onto
   // them and the extension is done locally.
   function automatic logic [5:0] op_ram_code(input logic [5:0] op);
      logic [5:0] c;
      case (op)
         OP_LBU:  c = OP_LB;
         OP_LHU:  c = OP_LH;
         default: c = op;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_access_initiator_load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
//   Combinational sign/zero extension of right-justified load data.
//   Ports:
//     op   in  6   normalized request opcode
//     raw  in  32  data returned by the RAM (right-justified, zero-filled)
//     ext  out 32  extended result (LB/LH sign, LBU/LHU zero, others as-is)
// -----------------------------------------------------------------------------
module load_extender
   import mem_access_initiator_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = raw;
      case (op)
         OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
         OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
         OP_LBU:  ext = {24'h0, raw[7:0]};
         OP_LHU:  ext = {16'h0, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_initiator.sv
// -----------------------------------------------------------------------------
// mem_access_initiator
//   Initiator side of the MOV/MOC RAM handshake. Takes one load/store request
//   at a time, checks alignment and range, drives the RAM, waits for MOC (with
//   a timeout) and returns a one-cycle response with extended load data.
//
//   Handshake: a request transfers on a rising Clk edge where req_valid and
//   req_ready are both 1; req_ready is 1 only in IDLE, so the requester holds
//   req_valid until then. rsp_valid is a single-cycle pulse with no back
//   pressure. Towards the RAM, MOV rises with address/data/RW/MemOP already
//   stable and they stay stable until MOV falls; the RAM answers with MOC.
//
//   Ports:
//     Clk, Clr                   clock, async active-high reset
//     req_valid/req_ready        request handshake
//     req_op/req_addr/req_wdata  request opcode, byte address, store data
//     rsp_valid/rsp_fault        one-cycle completion pulse, abort flag
//     rsp_rdata/rsp_code         extended load data, status (held)
//     MOV/RW/MemAddr/MemDataIn/MemOP   RAM command side
//     MemDataOut/MOC             RAM response side
//     dbg_state                  current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module mem_access_initiator
   import mem_access_initiator_pkg::*;
#(
   parameter int unsigned MEM_BYTES   = 512,
   parameter int unsigned TIMEOUT_CYC = 16
)(
   input  logic        Clk,
   input  logic        Clr,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic [1:0]  rsp_code,
   output logic        MOV,
   output logic        RW,
   output logic [31:0] MemAddr,
   output logic [31:0] MemDataIn,
   output logic [5:0]  MemOP,
   input  logic [31:0] MemDataOut,
   input  logic        MOC,
   output logic [2:0]  dbg_state
);

   localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT_CYC - 1);
   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   state_e      state_q, state_d;
   logic [5:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [7:0]  tmo_cnt_q;

   size_e       chk_size;
   logic        chk_misaligned;
   logic [32:0] chk_end;
   logic [1:0]  chk_code;
   logic        timeout_hit;
   logic [31:0] ext_data;

   assign dbg_state = state_q;

   // ---------------------------------------------------------------- checker
   // End address is formed in 33 bits so an access near 0xFFFF_FFFF cannot
   // wrap back into range.
   always_comb begin
      chk_size       = op_size(op_q);
      chk_misaligned = 1'b0;
      case (chk_size)
         SZ_HALF: chk_misaligned = addr_q[0];
         SZ_WORD: chk_misaligned = |addr_q[1:0];
         default: chk_misaligned = 1'b0;
      endcase
      chk_end = {1'b0, addr_q} + {30'd0, size_bytes(chk_size)};
      if (chk_misaligned)
         chk_code = CODE_MISALIGN;
      else if (chk_end > MEM_LIMIT)
         chk_code = CODE_RANGE;
      else
         chk_code = CODE_OK;
   end

   assign timeout_hit = (tmo_cnt_q == TMO_LAST);

   load_extender u_load_extender (
      .op  (op_q),
      .raw (MemDataOut),
      .ext (ext_data)
   );

   // ----------------------------------------------------------- state register
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // --------------------------------------------------------------- next state
   // MOC is not looked at in SETUP: it may still be high from the previous
   // access. In WAIT a MOC arriving on the timeout cycle still wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_valid) state_d = ST_CHECK;
         ST_CHECK: state_d = (chk_code != CODE_OK) ? ST_DONE : ST_SETUP;
         ST_SETUP: state_d = ST_WAIT;
         ST_WAIT:  if (MOC || timeout_hit) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // MOV decodes straight from the state register, so Clr drops it without
   // waiting for a clock edge.
   always_comb begin
      req_ready = 1'b0;
      MOV       = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE:           req_ready = 1'b1;
         ST_SETUP, ST_WAIT: MOV       = 1'b1;
         ST_DONE:           rsp_valid = 1'b1;
         default: ;
      endcase
      RW        = ~(MOV & op_is_store(op_q));
      rsp_fault = rsp_valid & (rsp_code != CODE_OK);
   end

   // ------------------------------------------------------------ request regs
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         op_q    <= OP_LW;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state_q == ST_IDLE && req_valid) begin
         op_q    <= op_normalize(req_op);
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // ---------------------------------------------------------------- RAM regs
   // Loaded once on the way into SETUP and held until the next access, so
   // they are stable for the whole MOV window.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         MemAddr   <= '0;
         MemDataIn <= '0;
         MemOP     <= OP_LW;
      end else if (state_q == ST_CHECK && chk_code == CODE_OK) begin
         MemAddr   <= addr_q;
         MemDataIn <= wdata_q;
         MemOP     <= op_ram_code(op_q);
      end
   end

   // ---------------------------------------------------------- timeout counter
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr)
         tmo_cnt_q <= '0;
      else if (state_q == ST_WAIT && state_d == ST_WAIT)
         tmo_cnt_q <= tmo_cnt_q + 8'd1;
      else
         tmo_cnt_q <= '0;
   end

   // ----------------------------------------------------------- response regs
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         rsp_rdata <= '0;
         rsp_code  <= CODE_OK;
      end else if (state_q == ST_CHECK && chk_code != CODE_OK) begin
         rsp_rdata <= '0;
         rsp_code  <= chk_code;
      end else if (state_q == ST_WAIT && MOC) begin
         rsp_rdata <= op_is_store(op_q) ? 32'h0 : ext_data;
         rsp_code  <= CODE_OK;
      end else if (state_q == ST_WAIT && timeout_hit) begin
         rsp_rdata <= '0;
         rsp_code  <= CODE_TIMEOUT;
      end
   end

endmodule

// File: tb/tb_mem_access_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_access_initiator
//   Directed bench: mem_access_initiator against a behavioural big-endian RAM
//   with a programmable MOC delay (or MOC held low).
// -----------------------------------------------------------------------------
module tb_mem_access_initiator;

   // ------------------------------------------------------- clock and reset
   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_op = 6'b100011;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [1:0]  rsp_code;
   logic        mov;
   logic        rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [5:0]  mem_op;
   logic [31:0] mem_dout = '0;
   logic        moc = 1'b0;
   logic [2:0]  dbg_state;

   mem_access_initiator #(.MEM_BYTES(512), .TIMEOUT_CYC(16)) dut (
      .Clk        (clk),
      .Clr        (clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault),
      .rsp_code   (rsp_code),
      .MOV        (mov),
      .RW         (rw),
      .MemAddr    (mem_addr),
      .MemDataIn  (mem_din),
      .MemOP      (mem_op),
      .MemDataOut (mem_dout),
      .MOC        (moc),
      .dbg_state  (dbg_state)
   );

   // ------------------------------------------------------- behavioural RAM
   logic [7:0] ram [0:511];
   int         moc_delay    = 0;
   logic       moc_hold_low = 1'b0;
   int         ram_cnt      = 0;
   logic [8:0] a0, a1, a2, a3;
   assign a0 = mem_addr[8:0];
   assign a1 = a0 + 9'd1;
   assign a2 = a0 + 9'd2;
   assign a3 = a0 + 9'd3;

   always @(posedge clk) begin
      if (!mov) begin
         moc     <= 1'b0;
         ram_cnt <= 0;
      end else if (!moc && !moc_hold_low) begin
         if (ram_cnt >= moc_delay) begin
            moc <= 1'b1;
            case (mem_op)
               6'b100000: mem_dout <= {24'h0, ram[a0]};
               6'b100001: mem_dout <= {16'h0, ram[a0], ram[a1]};
               6'b100011: mem_dout <= {ram[a0], ram[a1], ram[a2], ram[a3]};
               6'b101000: ram[a0] <= mem_din[7:0];
               6'b101001: begin
                  ram[a0] <= mem_din[15:8];
                  ram[a1] <= mem_din[7:0];
               end
               6'b101011: begin
                  ram[a0] <= mem_din[31:24];
                  ram[a1] <= mem_din[23:16];
                  ram[a2] <= mem_din[15:8];
                  ram[a3] <= mem_din[7:0];
               end
               default: mem_dout <= 32'h0;
            endcase
         end else begin
            ram_cnt <= ram_cnt + 1;
         end
      end
   end

   // ------------------------------------------------------------ bookkeeping
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // results of the last transaction
   logic [31:0] r_rdata;
   logic [1:0]  r_code;
   logic        r_fault;
   int          r_cycles;
   logic        r_mov_seen;
   logic [5:0]  r_op_seen;
   logic        r_mov_at_rsp;
   logic        r_rw_seen;

   // ---------------------------------------------------------------- driver
   // r_cycles counts clock cycles after the accepting edge up to and
   // including the cycle in which rsp_valid is high.
   task automatic do_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata);
      int  guard;
      logic got_rsp;
      @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      r_cycles     = 0;
      r_mov_seen   = 1'b0;
      r_op_seen    = 6'h00;
      r_rw_seen    = 1'b1;
      r_mov_at_rsp = 1'b0;
      got_rsp      = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         r_cycles++;
         if (mov) begin
            r_mov_seen = 1'b1;
            r_op_seen  = mem_op;
            r_rw_seen  = rw;
         end
         if (rsp_valid) begin
            r_rdata      = rsp_rdata;
            r_code       = rsp_code;
            r_fault      = rsp_fault;
            r_mov_at_rsp = mov;
            got_rsp      = 1'b1;
            break;
         end
      end
      if (!got_rsp) check("rsp_valid_timeout", 32'd0, 32'd1);
   endtask

   // ---------------------------------------------------------------- stimulus
   int rsp_cnt;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_mov",       32'(mov),       32'd0);
      check("rst_rw",        32'(rw),        32'd1);
      check("rst_memop",     32'(mem_op),    32'h23);
      check("rst_memaddr",   mem_addr,       32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_code",  32'(rsp_code),  32'd0);
      check("rst_rsp_rdata", rsp_rdata,      32'h0);

      // word store then load, zero wait states
      do_req(6'b101011, 32'h10, 32'hDEAD_BEEF);
      check("sw_code",    32'(r_code),   32'd0);
      check("sw_fault",   32'(r_fault),  32'd0);
      check("sw_rdata",   r_rdata,       32'h0);
      check("sw_rw",      32'(r_rw_seen), 32'd0);
      check("sw_memop",   32'(r_op_seen), 32'h2B);
      do_req(6'b100011, 32'h10, 32'h0);
      check("lw_rdata",   r_rdata,        32'hDEAD_BEEF);
      check("lw_code",    32'(r_code),    32'd0);
      check("lw_latency", r_cycles,       32'd4);
      check("lw_rw",      32'(r_rw_seen), 32'd1);
      check("lw_mov_done", 32'(r_mov_at_rsp), 32'd0);
      @(negedge clk);
      check("rsp_pulse_one_cycle", 32'(rsp_valid), 32'd0);
      check("rsp_rdata_held",      rsp_rdata,      32'hDEAD_BEEF);

      // byte store, signed and unsigned byte loads
      do_req(6'b101000, 32'h20, 32'h0000_0080);
      check("sb_memop",  32'(r_op_seen), 32'h28);
      do_req(6'b100000, 32'h20, 32'h0);
      check("lb_rdata",  r_rdata, 32'hFFFF_FF80);
      do_req(6'b100100, 32'h20, 32'h0);
      check("lbu_rdata", r_rdata, 32'h0000_0080);
      check("lbu_memop", 32'(r_op_seen), 32'h20);

      // halfword store, signed and unsigned halfword loads
      do_req(6'b101001, 32'h40, 32'h1234_8001);
      do_req(6'b100001, 32'h40, 32'h0);
      check("lh_rdata",  r_rdata, 32'hFFFF_8001);
      do_req(6'b100101, 32'h40, 32'h0);
      check("lhu_rdata", r_rdata, 32'h0000_8001);
      check("lhu_memop", 32'(r_op_seen), 32'h21);

      // illegal opcode behaves as LW
      do_req(6'b111111, 32'h10, 32'h0);
      check("illegal_rdata", r_rdata, 32'hDEAD_BEEF);
      check("illegal_memop", 32'(r_op_seen), 32'h23);
      check("illegal_code",  32'(r_code), 32'd0);

      // alignment and range
      do_req(6'b100001, 32'h31, 32'h0);
      check("lh31_fault",   32'(r_fault),    32'd1);
      check("lh31_code",    32'(r_code),     32'd1);
      check("lh31_no_mov",  32'(r_mov_seen), 32'd0);
      check("lh31_latency", r_cycles,        32'd2);
      check("lh31_rdata",   r_rdata,         32'h0);
      do_req(6'b100011, 32'h1FE, 32'h0);
      check("lw1fe_code",   32'(r_code),     32'd1);
      do_req(6'b100011, 32'h1FC, 32'h0);
      check("lw1fc_code",   32'(r_code),     32'd0);
      check("lw1fc_fault",  32'(r_fault),    32'd0);
      do_req(6'b100011, 32'h200, 32'h0);
      check("lw200_code",   32'(r_code),     32'd2);
      check("lw200_no_mov", 32'(r_mov_seen), 32'd0);
      do_req(6'b101001, 32'h1FF, 32'h0);
      check("sh1ff_code",   32'(r_code),     32'd1);
      do_req(6'b100000, 32'hFFFF_FFFF, 32'h0);
      check("lbffff_code",  32'(r_code),     32'd2);
      check("lbffff_fault", 32'(r_fault),    32'd1);

      // wait states
      moc_delay = 3;
      do_req(6'b100011, 32'h10, 32'h0);
      check("wait3_latency", r_cycles, 32'd7);
      check("wait3_rdata",   r_rdata,  32'hDEAD_BEEF);

      // MOC never arrives: 16 WAIT cycles then timeout
      moc_hold_low = 1'b1;
      do_req(6'b100011, 32'h10, 32'h0);
      check("tmo_code",    32'(r_code),       32'd3);
      check("tmo_fault",   32'(r_fault),      32'd1);
      check("tmo_latency", r_cycles,          32'd19);
      check("tmo_mov_low", 32'(r_mov_at_rsp), 32'd0);
      check("tmo_rdata",   r_rdata,           32'h0);
      moc_hold_low = 1'b0;

      // MOC on the last allowed WAIT cycle wins over the timeout
      moc_delay = 15;
      do_req(6'b100011, 32'h10, 32'h0);
      check("late_moc_code",    32'(r_code), 32'd0);
      check("late_moc_rdata",   r_rdata,     32'hDEAD_BEEF);
      check("late_moc_latency", r_cycles,    32'd19);

      // Clr in the middle of WAIT
      moc_delay = 10;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 6'b100011;
      req_addr  = 32'h10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("clr_pre_state", 32'(dbg_state), 32'd3);
      check("clr_pre_mov",   32'(mov),       32'd1);
      #2 clr = 1'b1;
      #1;
      check("clr_mov_drop",  32'(mov),       32'd0);
      check("clr_rsp_rdata", rsp_rdata,      32'h0);
      @(negedge clk);
      clr = 1'b0;
      rsp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) rsp_cnt++;
      end
      check("clr_no_rsp",    rsp_cnt,        32'd0);
      check("clr_req_ready", 32'(req_ready), 32'd1);
      moc_delay = 0;
      do_req(6'b100011, 32'h10, 32'h0);
      check("post_clr_rdata",   r_rdata,     32'hDEAD_BEEF);
      check("post_clr_code",    32'(r_code), 32'd0);
      check("post_clr_latency", r_cycles,    32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
